// File: rtl/cache_axi_pkg.sv
// Shared type codes, AXI encodings and FSM state types for the cache-to-AXI bridge.
package cache_axi_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [2:0] SIZE_1B = 3'd0;
  localparam logic [2:0] SIZE_2B = 3'd1;
  localparam logic [2:0] SIZE_4B = 3'd2;

  // Line address is addr[31:LINE_LSB]; used for the read-after-write hazard compare.
  localparam int LINE_LSB = 4;
  localparam int LINE_W   = 32 - LINE_LSB;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  function automatic logic [2:0] axi_size(input logic [2:0] req_type);
    case (req_type)
      TYPE_BYTE: return SIZE_1B;
      TYPE_HALF: return SIZE_2B;
      default:   return SIZE_4B;
    endcase
  endfunction

  function automatic logic [7:0] axi_len(input logic [2:0] req_type, input int beats);
    return (req_type == TYPE_LINE) ? 8'(beats - 1) : 8'd0;
  endfunction

endpackage

// File: rtl/cache_axi_wbuf.sv
// Single-entry write buffer and AXI AW/W sequencer: holds one request, issues AW and
// the W beats independently, and flags when both address and last data beat are done.
module cache_axi_wbuf
  import cache_axi_pkg::*;
#(
  parameter int LINE_BEATS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [2:0]                ld_type,
  input  logic [31:0]               ld_addr,
  input  logic [3:0]                ld_wstrb,
  input  logic [32*LINE_BEATS-1:0]  ld_data,
  input  logic                      sending,
  output logic [31:0]               awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [31:0]               wdata,
  output logic [3:0]                wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  output logic                      send_done,
  output logic [LINE_W-1:0]         buf_line
);

  localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  logic [31:0]               addr_q;
  logic [2:0]                type_q;
  logic [3:0]                strb_q;
  logic [32*LINE_BEATS-1:0]  data_q;
  logic [BW-1:0]             beat_q;
  logic                      aw_done_q;
  logic                      w_done_q;
  logic                      is_line;
  logic                      last_beat;
  logic                      aw_hs;
  logic                      w_hs;

  assign is_line   = (type_q == TYPE_LINE);
  assign last_beat = is_line ? (beat_q == BW'(LINE_BEATS - 1)) : 1'b1;

  assign awvalid = sending && !aw_done_q;
  assign wvalid  = sending && !w_done_q;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  assign awaddr  = addr_q;
  assign awlen   = axi_len(type_q, LINE_BEATS);
  assign awsize  = axi_size(type_q);
  assign awburst = BURST_INCR;

  // Non-line writes never advance the beat counter, so they always present word 0.
  assign wdata = data_q[{beat_q, 5'b0} +: 32];
  assign wstrb = is_line ? 4'hf : strb_q;
  assign wlast = wvalid && last_beat;

  // Either half may complete in the same cycle as the other.
  assign send_done = (aw_done_q || aw_hs) && (w_done_q || (w_hs && last_beat));
  assign buf_line  = addr_q[31:LINE_LSB];

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      type_q    <= TYPE_BYTE;
      strb_q    <= '0;
      data_q    <= '0;
      beat_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (load) begin
      addr_q    <= ld_addr;
      type_q    <= ld_type;
      strb_q    <= ld_wstrb;
      data_q    <= ld_data;
      beat_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (sending) begin
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs) begin
        if (last_beat) w_done_q <= 1'b1;
        else           beat_q   <= beat_q + BW'(1);
      end
    end
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache refill/writeback to AXI4 master bridge: independent read and write FSMs, a
// one-entry write buffer, and a line-address hazard that holds reads behind same-line writes.
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter int LINE_BEATS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_req,
  input  logic [2:0]                rd_type,
  input  logic [31:0]               rd_addr,
  output logic                      rd_rdy,
  output logic                      ret_valid,
  output logic                      ret_last,
  output logic [31:0]               ret_data,
  input  logic                      wr_req,
  input  logic [2:0]                wr_type,
  input  logic [31:0]               wr_addr,
  input  logic [3:0]                wr_wstrb,
  input  logic [32*LINE_BEATS-1:0]  wr_data,
  output logic                      wr_rdy,
  output logic [31:0]               araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [31:0]               awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [31:0]               wdata,
  output logic [3:0]                wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready
);

  r_state_t          r_state, r_next;
  w_state_t          w_state, w_next;
  logic              rd_acc;
  logic              wr_acc;
  logic              hazard;
  logic              sending;
  logic              send_done;
  logic [LINE_W-1:0] wbuf_line;
  logic              resp_unused;

  // Response codes carry no meaning for the cache; data is forwarded regardless.
  assign resp_unused = ^{rresp, bresp};

  assign wr_rdy = (w_state == W_IDLE);
  assign wr_acc = wr_req && wr_rdy;

  // Covers both a write already buffered and one being accepted this very cycle.
  assign hazard = ((w_state != W_IDLE) && (rd_addr[31:LINE_LSB] == wbuf_line)) ||
                  (wr_acc && (rd_addr[31:LINE_LSB] == wr_addr[31:LINE_LSB]));

  assign rd_rdy = (r_state == R_IDLE) && !hazard;
  assign rd_acc = rd_req && rd_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      araddr  <= '0;
      arlen   <= '0;
      arsize  <= '0;
    end else begin
      r_state <= r_next;
      if (rd_acc) begin
        araddr <= rd_addr;
        arlen  <= axi_len(rd_type, LINE_BEATS);
        arsize <= axi_size(rd_type);
      end
    end
  end

  always_comb begin
    r_next  = r_state;
    arvalid = 1'b0;
    rready  = 1'b0;
    case (r_state)
      R_IDLE: if (rd_acc) r_next = R_AR;
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_next = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign arburst   = BURST_INCR;
  assign ret_valid = rready && rvalid;
  assign ret_last  = ret_valid && rlast;
  assign ret_data  = rdata;

  always_ff @(posedge clk) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    sending = 1'b0;
    bready  = 1'b0;
    case (w_state)
      W_IDLE: if (wr_acc) w_next = W_SEND;
      W_SEND: begin
        sending = 1'b1;
        if (send_done) w_next = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  cache_axi_wbuf #(
    .LINE_BEATS (LINE_BEATS)
  ) u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .load      (wr_acc),
    .ld_type   (wr_type),
    .ld_addr   (wr_addr),
    .ld_wstrb  (wr_wstrb),
    .ld_data   (wr_data),
    .sending   (sending),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .send_done (send_done),
    .buf_line  (wbuf_line)
  );

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed plus randomized bench for cache_axi_bridge with a behavioural AXI slave and request model.
module tb_cache_axi_bridge;

  localparam logic [2:0] T_BYTE = 3'b000;
  localparam logic [2:0] T_HALF = 3'b001;
  localparam logic [2:0] T_WORD = 3'b010;
  localparam logic [2:0] T_LINE = 3'b100;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  int vectors = 0;
  int miscompares = 0;

  cache_axi_bridge #(.LINE_BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: bytes moved per beat and beats per request, straight from the request type.
  function automatic int m_bytes(input logic [2:0] t);
    case (t)
      T_BYTE:  return 1;
      T_HALF:  return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] m_size(input logic [2:0] t);
    return 3'($clog2(m_bytes(t)));
  endfunction

  function automatic int m_beats(input logic [2:0] t);
    return (t == T_LINE) ? 4 : 1;
  endfunction

  function automatic logic [7:0] m_len(input logic [2:0] t);
    return 8'(m_beats(t) - 1);
  endfunction

  function automatic logic [2:0] rand_type();
    case ($urandom_range(0, 3))
      0:       return T_BYTE;
      1:       return T_HALF;
      2:       return T_WORD;
      default: return T_LINE;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] typ, input logic [31:0] base);
    int n;
    int k;
    logic [31:0] d;
    n = m_beats(typ);
    rd_addr = addr;
    rd_type = typ;
    #1;
    k = 0;
    while (!rd_rdy && k < 50) begin
      cyc(); #1; k++;
    end
    chk("rd_rdy_idle", 32'(rd_rdy), 32'd1);
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    #1;
    chk("arvalid_rise", 32'(arvalid), 32'd1);
    chk("araddr", araddr, addr);
    chk("arlen", 32'(arlen), 32'(m_len(typ)));
    chk("arsize", 32'(arsize), 32'(m_size(typ)));
    chk("arburst", 32'(arburst), 32'd1);
    chk("rd_rdy_busy", 32'(rd_rdy), 32'd0);
    repeat ($urandom_range(0, 2)) begin
      cyc(); #1;
      chk("ar_hold_vld", 32'(arvalid), 32'd1);
      chk("ar_hold_addr", araddr, addr);
    end
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    #1;
    chk("arvalid_drop", 32'(arvalid), 32'd0);
    chk("rready_data", 32'(rready), 32'd1);
    for (int b = 0; b < n; b++) begin
      repeat ($urandom_range(0, 2)) begin
        chk("ret_idle", 32'(ret_valid), 32'd0);
        cyc(); #1;
      end
      d      = base + 32'(b);
      rvalid = 1'b1;
      rdata  = d;
      rlast  = (b == n - 1);
      rresp  = 2'($urandom);
      #1;
      chk("ret_valid", 32'(ret_valid), 32'd1);
      chk("ret_data", ret_data, d);
      chk("ret_last", 32'(ret_last), 32'(b == n - 1));
      cyc();
      rvalid = 1'b0;
      rlast  = 1'b0;
      rdata  = '0;
      #1;
    end
    chk("rd_rdy_after_last", 32'(rd_rdy), 32'd1);
    chk("rready_after_last", 32'(rready), 32'd0);
  endtask

  // aw_after < 0: random AW acceptance; otherwise AW is accepted aw_after cycles after the last W beat.
  task automatic do_write(input logic [31:0] addr, input logic [2:0] typ, input logic [127:0] data,
                          input logic [3:0] strb, input int aw_after);
    int n;
    int beat;
    int since;
    int k;
    bit aw_ok;
    bit w_ok;
    bit same;
    logic [31:0] probe;
    logic [31:0] exp_w;
    n = m_beats(typ);
    wr_addr  = addr;
    wr_type  = typ;
    wr_data  = data;
    wr_wstrb = strb;
    #1;
    k = 0;
    while (!wr_rdy && k < 50) begin
      cyc(); #1; k++;
    end
    chk("wr_rdy_idle", 32'(wr_rdy), 32'd1);
    wr_req = 1'b1;
    cyc();
    wr_req = 1'b0;
    #1;
    chk("awvalid_rise", 32'(awvalid), 32'd1);
    chk("wvalid_rise", 32'(wvalid), 32'd1);
    chk("awaddr", awaddr, addr);
    chk("awlen", 32'(awlen), 32'(m_len(typ)));
    chk("awsize", 32'(awsize), 32'(m_size(typ)));
    chk("awburst", 32'(awburst), 32'd1);
    chk("wr_rdy_busy", 32'(wr_rdy), 32'd0);
    beat = 0; since = 0; aw_ok = 0; w_ok = 0; k = 0;
    while (!(aw_ok && w_ok) && k < 200) begin
      wready = 1'($urandom_range(0, 1));
      if (aw_after < 0) awready = 1'($urandom_range(0, 1));
      else              awready = w_ok && (since >= aw_after);
      same    = 1'($urandom_range(0, 1));
      probe   = same ? {addr[31:4], 4'($urandom)} : $urandom;
      rd_addr = probe;
      #1;
      chk("rd_rdy_hazard", 32'(rd_rdy), 32'(probe[31:4] != addr[31:4]));
      chk("bready_in_send", 32'(bready), 32'd0);
      chk("awvalid_send", 32'(awvalid), 32'(!aw_ok));
      chk("wvalid_send", 32'(wvalid), 32'(!w_ok));
      if (!w_ok) begin
        exp_w = (typ == T_LINE) ? data[32*beat +: 32] : data[31:0];
        chk("wdata", wdata, exp_w);
        chk("wstrb", 32'(wstrb), 32'((typ == T_LINE) ? 4'hf : strb));
        chk("wlast", 32'(wlast), 32'(beat == n - 1));
      end
      if (!w_ok && wready) begin
        beat++;
        if (beat == n) w_ok = 1;
      end else if (w_ok) begin
        since++;
      end
      if (awready) aw_ok = 1;
      cyc();
      wready  = 1'b0;
      awready = 1'b0;
      k++;
    end
    #1;
    chk("bready_resp", 32'(bready), 32'd1);
    chk("awvalid_resp", 32'(awvalid), 32'd0);
    chk("wvalid_resp", 32'(wvalid), 32'd0);
    chk("wr_rdy_resp", 32'(wr_rdy), 32'd0);
    repeat ($urandom_range(0, 2)) begin
      cyc(); #1;
      chk("bready_wait", 32'(bready), 32'd1);
      chk("wr_rdy_wait", 32'(wr_rdy), 32'd0);
    end
    bvalid = 1'b1;
    bresp  = 2'($urandom);
    cyc();
    bvalid = 1'b0;
    #1;
    chk("wr_rdy_after_b", 32'(wr_rdy), 32'd1);
    chk("bready_after_b", 32'(bready), 32'd0);
    rd_addr = '0;
  endtask

  initial begin
    logic [127:0] d128;
    reset = 1'b1;
    rd_req = 0; rd_type = T_BYTE; rd_addr = '0;
    wr_req = 0; wr_type = T_BYTE; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    arready = 0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = '0; bvalid = 0;
    repeat (3) cyc();
    #1;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_ret_valid", 32'(ret_valid), 32'd0);
    chk("rst_ret_last", 32'(ret_last), 32'd0);
    chk("rst_rd_rdy", 32'(rd_rdy), 32'd1);
    chk("rst_wr_rdy", 32'(wr_rdy), 32'd1);
    reset = 1'b0;
    cyc();

    do_read(32'h1000_0040, T_LINE, 32'hA0);
    do_write(32'h2000_0010, T_LINE, 128'h00004444_00003333_00002222_00001111, 4'h0, -1);
    do_write(32'h0000_0003, T_BYTE, {$urandom, $urandom, $urandom, $urandom}, 4'b1000, -1);

    // Same-cycle read and write to different lines, then a same-line read held off by the write.
    rd_addr = 32'h200; rd_type = T_LINE;
    wr_addr = 32'h100; wr_type = T_WORD; wr_wstrb = 4'hf; wr_data = 128'h0123_4567_89ab_cdef_0000_0000_dead_beef;
    #1;
    chk("par_rd_rdy", 32'(rd_rdy), 32'd1);
    chk("par_wr_rdy", 32'(wr_rdy), 32'd1);
    rd_req = 1'b1; wr_req = 1'b1;
    cyc();
    rd_req = 1'b0; wr_req = 1'b0;
    #1;
    chk("par_arvalid", 32'(arvalid), 32'd1);
    chk("par_awvalid", 32'(awvalid), 32'd1);
    chk("par_wvalid", 32'(wvalid), 32'd1);
    chk("par_araddr", araddr, 32'h200);
    chk("par_awaddr", awaddr, 32'h100);
    chk("par_wdata", wdata, 32'hdead_beef);
    chk("par_wlast", 32'(wlast), 32'd1);
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    cyc();
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    #1;
    chk("par_rready", 32'(rready), 32'd1);
    chk("par_bready", 32'(bready), 32'd1);
    for (int b = 0; b < 4; b++) begin
      rvalid = 1'b1; rdata = 32'h5500 + 32'(b); rlast = (b == 3);
      #1;
      chk("par_ret_data", ret_data, 32'h5500 + 32'(b));
      chk("par_ret_last", 32'(ret_last), 32'(b == 3));
      cyc();
    end
    rvalid = 1'b0; rlast = 1'b0;
    rd_addr = 32'h10C;
    #1;
    chk("haz_rd_rdy", 32'(rd_rdy), 32'd0);
    repeat (3) begin
      cyc(); #1;
      chk("haz_hold", 32'(rd_rdy), 32'd0);
    end
    bvalid = 1'b1;
    #1;
    chk("haz_during_b", 32'(rd_rdy), 32'd0);
    cyc();
    bvalid = 1'b0;
    #1;
    chk("haz_wr_rdy", 32'(wr_rdy), 32'd1);
    chk("haz_released", 32'(rd_rdy), 32'd1);
    do_read(32'h10C, T_WORD, 32'h77);

    do_write(32'h6000_0020, T_LINE, {$urandom, $urandom, $urandom, $urandom}, 4'hf, 5);

    // A write being accepted this cycle also blocks a same-line read.
    rd_addr = 32'h500; wr_addr = 32'h508; wr_req = 1'b1;
    #1;
    chk("same_cycle_haz", 32'(rd_rdy), 32'd0);
    wr_addr = 32'h518;
    #1;
    chk("same_cycle_nohaz", 32'(rd_rdy), 32'd1);
    wr_req = 1'b0;
    cyc();

    // Reset while beat 2 of a line read is on the bus.
    rd_addr = 32'h4000_0080; rd_type = T_LINE;
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0; arready = 1'b1;
    cyc();
    arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1; rdata = 32'hB0 + 32'(b);
      cyc();
    end
    rvalid = 1'b1; rdata = 32'hB2; reset = 1'b1;
    #1;
    chk("rst_mid_beat2", 32'(ret_valid), 32'd1);
    cyc();
    reset = 1'b0; rvalid = 1'b0;
    #1;
    chk("rstm_arvalid", 32'(arvalid), 32'd0);
    chk("rstm_rready", 32'(rready), 32'd0);
    chk("rstm_ret_valid", 32'(ret_valid), 32'd0);
    chk("rstm_awvalid", 32'(awvalid), 32'd0);
    chk("rstm_wvalid", 32'(wvalid), 32'd0);
    chk("rstm_bready", 32'(bready), 32'd0);
    chk("rstm_rd_rdy", 32'(rd_rdy), 32'd1);
    chk("rstm_wr_rdy", 32'(wr_rdy), 32'd1);
    do_read(32'h4000_0080, T_LINE, 32'hC0);

    // Reset partway through a line write; the next write must restart at word 0.
    d128 = {$urandom, $urandom, $urandom, $urandom};
    wr_addr = 32'h5000_0000; wr_type = T_LINE; wr_data = d128; wr_req = 1'b1;
    cyc();
    wr_req = 1'b0; wready = 1'b1;
    repeat (2) cyc();
    wready = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("rstw_wr_rdy", 32'(wr_rdy), 32'd1);
    chk("rstw_wvalid", 32'(wvalid), 32'd0);
    chk("rstw_awvalid", 32'(awvalid), 32'd0);
    do_write(32'h5000_0040, T_LINE, {$urandom, $urandom, $urandom, $urandom}, 4'hf, -1);

    for (int i = 0; i < 24; i++) begin
      logic [2:0] t;
      t = rand_type();
      if ($urandom_range(0, 1) == 1)
        do_read($urandom, t, $urandom);
      else
        do_write($urandom, t, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom),
                 ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
